pipe_control_unit: RTL and testbench

//  Control/sequencing unit that sits directly upstream of the 5-stage datapath.
//  It decodes the 4-bit decode-stage opcode (opcodeDP) into the per-instruction

---
 rtl/pipe_control_unit.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// pipe_control_unit
//   Control and sequencing unit sitting in front of the 5-stage datapath.
//   Decodes the decode-stage opcode into the control bundle sampled by the
//   execute register, and sequences the pipeline: start-up gating, a one-cycle
//   flush after a taken branch, a fixed-length drain after HALT, and saturating
//   cycle / instruction counters.
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start           leaves IDLE (only sampled in IDLE)
//   opcodeDP        opcode of the instruction in decode
//   enable          PC + decode-register enable
//   branchC         selects branch target into the PC mux
//   flushC          clears the execute register on the next edge
//   RegWriteC, MemWriteC, MemToRegC, immediateC, alufuncC
//                   decoded control bundle (alufunc 00 ADD, 01 SUB, 10 AND, 11 OR)
//   halted          pipeline fully drained after HALT
//   illegal_op      sticky flag: undefined opcode decoded in RUN
//   cycle_count     cycles spent in RUN/FLUSH/DRAIN (saturating)
//   instr_count     instructions issued from decode (saturating)
module pipe_control_unit #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcodeDP,
  output logic             enable,
  output logic             branchC,
  output logic             flushC,
  output logic             RegWriteC,
  output logic             MemWriteC,
  output logic             MemToRegC,
  output logic             immediateC,
  output logic [1:0]       alufuncC,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ADD    = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_AND    = 4'h3;
  localparam logic [3:0] OP_OR     = 4'h4;
  localparam logic [3:0] OP_ADDI   = 4'h5;
  localparam logic [3:0] OP_SUBI   = 4'h6;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_STORE  = 4'h9;
  localparam logic [3:0] OP_BRANCH = 4'hA;
  localparam logic [3:0] OP_HALT   = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t          state_r;
  state_t          nextState_s;
  logic [DW-1:0]   drainCnt_r;
  logic            illegalDec_s;
  logic            counting_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Drain length counter; restarts from 0 every time DRAIN is entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drainCnt_r <= '0;
    end else if (state_r == DRAIN) begin
      drainCnt_r <= drainCnt_r + DW'(1);
    end else begin
      drainCnt_r <= '0;
    end
  end

  // Next-state logic
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          nextState_s = RUN;
        end else begin
          nextState_s = IDLE;
        end
      end
      RUN: begin
        if (opcodeDP == OP_BRANCH) begin
          nextState_s = FLUSH;
        end else if (opcodeDP == OP_HALT) begin
          nextState_s = DRAIN;
        end else begin
          nextState_s = RUN;
        end
      end
      // The squashed wrong-path opcode is never looked at here.
      FLUSH: nextState_s = RUN;
      DRAIN: begin
        if (drainCnt_r == DRAIN_LAST) begin
          nextState_s = HALTED;
        end else begin
          nextState_s = DRAIN;
        end
      end
      HALTED:  nextState_s = HALTED;
      default: nextState_s = IDLE;
    endcase
  end

  // Output decode: zero-latency control bundle from state and opcode
  always_comb begin
    enable       = 1'b0;
    branchC      = 1'b0;
    flushC       = 1'b0;
    RegWriteC    = 1'b0;
    MemWriteC    = 1'b0;
    MemToRegC    = 1'b0;
    immediateC   = 1'b0;
    alufuncC     = 2'b00;
    illegalDec_s = 1'b0;
    case (state_r)
      RUN: begin
        enable = 1'b1;
        case (opcodeDP)
          OP_NOP: enable = 1'b1;
          OP_ADD: RegWriteC = 1'b1;
          OP_SUB: begin
            RegWriteC = 1'b1;
            alufuncC  = 2'b01;
          end
          OP_AND: begin
            RegWriteC = 1'b1;
            alufuncC  = 2'b10;
          end
          OP_OR: begin
            RegWriteC = 1'b1;
            alufuncC  = 2'b11;
          end
          OP_ADDI: begin
            RegWriteC  = 1'b1;
            immediateC = 1'b1;
          end
          OP_SUBI: begin
            RegWriteC  = 1'b1;
            immediateC = 1'b1;
            alufuncC   = 2'b01;
          end
          OP_LOAD: begin
            RegWriteC  = 1'b1;
            MemToRegC  = 1'b1;
            immediateC = 1'b1;
          end
          OP_STORE: begin
            MemWriteC  = 1'b1;
            immediateC = 1'b1;
          end
          OP_BRANCH: branchC = 1'b1;
          // Freeze PC and decode so the HALT stays put while the pipe drains.
          OP_HALT: enable = 1'b0;
          // Undefined opcodes behave as NOP but raise the sticky flag.
          default: illegalDec_s = 1'b1;
        endcase
      end
      FLUSH: begin
        enable = 1'b1;
        flushC = 1'b1;
      end
      default: enable = 1'b0;
    endcase
  end

  assign counting_s = (state_r == RUN) || (state_r == FLUSH) || (state_r == DRAIN);
  assign halted     = (state_r == HALTED);

  // Saturating counters and sticky illegal-opcode flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      if (counting_s && (cycle_count != CNT_MAX)) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      if ((state_r == RUN) && (opcodeDP != OP_HALT) && (instr_count != CNT_MAX)) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (illegalDec_s) begin
        illegal_op <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit. Two instances share stimulus:
// the default 16-bit counter build and a 4-bit counter build for saturation.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] opcodeDP;

  logic aEn, aBr, aFl, aRw, aMw, aMr, aImm, aHalt, aIll;
  logic bEn, bBr, bFl, bRw, bMw, bMr, bImm, bHalt, bIll;
  logic [1:0]  aAlu, bAlu;
  logic [15:0] aCyc, aIns;
  logic [3:0]  bCyc, bIns;

  pipe_control_unit #(.CNT_W(16), .DRAIN_CYCLES(3)) dutA (
    .clk(clk), .reset(reset), .start(start), .opcodeDP(opcodeDP),
    .enable(aEn), .branchC(aBr), .flushC(aFl), .RegWriteC(aRw), .MemWriteC(aMw),
    .MemToRegC(aMr), .immediateC(aImm), .alufuncC(aAlu), .halted(aHalt),
    .illegal_op(aIll), .cycle_count(aCyc), .instr_count(aIns));

  pipe_control_unit #(.CNT_W(4), .DRAIN_CYCLES(3)) dutB (
    .clk(clk), .reset(reset), .start(start), .opcodeDP(opcodeDP),
    .enable(bEn), .branchC(bBr), .flushC(bFl), .RegWriteC(bRw), .MemWriteC(bMw),
    .MemToRegC(bMr), .immediateC(bImm), .alufuncC(bAlu), .halted(bHalt),
    .illegal_op(bIll), .cycle_count(bCyc), .instr_count(bIns));

  always #5 clk = ~clk;

  // Observed vector: A bundle, B bundle, A counters, B counters
  logic [61:0] obs;
  assign obs = {aEn, aBr, aFl, aRw, aMw, aMr, aImm, aAlu, aHalt, aIll,
                bEn, bBr, bFl, bRw, bMw, bMr, bImm, bAlu, bHalt, bIll,
                aCyc, aIns, bCyc, bIns};

  int checks = 0;
  int errors = 0;

  // Reference model: spec-level pipeline phase plus plain integer counters
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_DRAIN = 3, M_HALTED = 4;
  int          mMode;
  int          mDrainLeft;
  int          mCyc;
  int          mInstr;
  bit          mIll;
  logic [6:0]  ctrlTab [16];   // {branch, RegWrite, MemWrite, MemToReg, imm, alu[1:0]}
  bit          legal [16];
  logic [61:0] expv;

  task automatic buildTable();
    for (int i = 0; i < 16; i++) begin
      ctrlTab[i] = 7'b0;
      legal[i]   = 1'b0;
    end
    ctrlTab[0]  = 7'b0_0000_00; legal[0]  = 1'b1;
    ctrlTab[1]  = 7'b0_1000_00; legal[1]  = 1'b1;
    ctrlTab[2]  = 7'b0_1000_01; legal[2]  = 1'b1;
    ctrlTab[3]  = 7'b0_1000_10; legal[3]  = 1'b1;
    ctrlTab[4]  = 7'b0_1000_11; legal[4]  = 1'b1;
    ctrlTab[5]  = 7'b0_1001_00; legal[5]  = 1'b1;
    ctrlTab[6]  = 7'b0_1001_01; legal[6]  = 1'b1;
    ctrlTab[8]  = 7'b0_1011_00; legal[8]  = 1'b1;
    ctrlTab[9]  = 7'b0_0101_00; legal[9]  = 1'b1;
    ctrlTab[10] = 7'b1_0000_00; legal[10] = 1'b1;
    ctrlTab[15] = 7'b0_0000_00; legal[15] = 1'b1;
  endtask

  task automatic modelReset();
    mMode = M_IDLE; mDrainLeft = 0; mCyc = 0; mInstr = 0; mIll = 1'b0;
  endtask

  // Drive inputs, move to the falling edge and form the expected vector
  task automatic drive(input logic st, input logic [3:0] op);
    logic [10:0] b;
    start    = st;
    opcodeDP = op;
    @(negedge clk);
    b = 11'b0;
    if (mMode == M_RUN) begin
      b[10]  = (op != 4'hF);
      b[9]   = ctrlTab[op][6];
      b[7:2] = ctrlTab[op][5:0];
    end else if (mMode == M_FLUSH) begin
      b[10] = 1'b1;
      b[8]  = 1'b1;
    end
    b[1] = (mMode == M_HALTED);
    b[0] = mIll;
    expv = {b, b,
            (mCyc   > 65535) ? 16'hFFFF : 16'(mCyc),
            (mInstr > 65535) ? 16'hFFFF : 16'(mInstr),
            (mCyc   > 15) ? 4'hF : 4'(mCyc),
            (mInstr > 15) ? 4'hF : 4'(mInstr)};
  endtask

  // Apply the clock edge to the model, then to the DUT
  task automatic advance();
    case (mMode)
      M_IDLE: if (start) mMode = M_RUN;
      M_RUN: begin
        mCyc++;
        if (opcodeDP != 4'hF) mInstr++;
        if (!legal[opcodeDP]) mIll = 1'b1;
        if (opcodeDP == 4'hA) mMode = M_FLUSH;
        else if (opcodeDP == 4'hF) begin
          mMode = M_DRAIN;
          mDrainLeft = 3;
        end
      end
      M_FLUSH: begin
        mCyc++;
        mMode = M_RUN;
      end
      M_DRAIN: begin
        mCyc++;
        mDrainLeft--;
        if (mDrainLeft == 0) mMode = M_HALTED;
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge
  task automatic doReset();
    reset = 1'b1;
    #2;
    checks++;
    if (obs !== 62'b0) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", obs, 62'b0);
    end
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'($urandom_range(0, 15)));
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %h exp %h", i, obs, expv);
      end
      advance();
    end
  endtask

  task automatic test_decode();
    logic [3:0] ops [5];
    ops = '{4'h0, 4'h1, 4'h5, 4'h8, 4'h9};
    doReset();
    drive(1'b1, ops[0]);   // IDLE cycle with start
    advance();
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, ops[i]);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL decode op %h got %h exp %h", ops[i], obs, expv);
      end
      advance();
    end
    drive(1'b0, 4'h0);
    checks++;
    if (aIns !== 16'd4) begin
      errors++;
      $display("FAIL decode_instr_count got %0d exp 4", aIns);
    end
    advance();
  endtask

  task automatic test_branch();
    // Branch, then an illegal and a HALT opcode sitting in decode during flush
    logic [3:0] ops [7];
    ops = '{4'h1, 4'hA, 4'hC, 4'h1, 4'hA, 4'hF, 4'h2};
    doReset();
    drive(1'b1, 4'h0);
    advance();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, ops[i]);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL branch step %0d op %h got %h exp %h", i, ops[i], obs, expv);
      end
      advance();
    end
  endtask

  task automatic test_halt();
    doReset();
    drive(1'b1, 4'h0);
    advance();
    drive(1'b0, 4'h3);
    advance();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) ? 4'hF : 4'($urandom_range(0, 15)));
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL halt step %0d got %h exp %h", i, obs, expv);
      end
      advance();
    end
    drive(1'b1, 4'h1);
    checks++;
    if (aHalt !== 1'b1 || aCyc !== 16'd5) begin
      errors++;
      $display("FAIL halt_final got halted %b cyc %0d exp halted 1 cyc 5", aHalt, aCyc);
    end
    advance();
  endtask

  task automatic test_illegal();
    logic [3:0] ops [5];
    ops = '{4'hC, 4'h1, 4'h7, 4'hE, 4'h0};
    doReset();
    drive(1'b1, 4'h0);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, ops[i]);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL illegal step %0d op %h got %h exp %h", i, ops[i], obs, expv);
      end
      advance();
    end
  endtask

  task automatic test_saturate();
    doReset();
    drive(1'b1, 4'h1);
    advance();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 4'h1);
      advance();
    end
    drive(1'b0, 4'h1);
    checks++;
    if (bCyc !== 4'hF || bIns !== 4'hF || aCyc !== 16'd20 || aIns !== 16'd20) begin
      errors++;
      $display("FAIL saturate got b %0d/%0d a %0d/%0d exp 15/15 20/20", bCyc, bIns, aCyc, aIns);
    end
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL saturate_model got %h exp %h", obs, expv);
    end
    advance();
  endtask

  task automatic test_reset_in_drain();
    doReset();
    drive(1'b1, 4'h0);
    advance();
    drive(1'b0, 4'h2);
    advance();
    drive(1'b0, 4'hF);
    advance();
    drive(1'b0, 4'h1);
    advance();
    doReset();
    drive(1'b0, 4'h1);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL reset_in_drain got %h exp %h", obs, expv);
    end
    advance();
  endtask

  task automatic test_random();
    logic [3:0] op;
    int haltedFor;
    doReset();
    haltedFor = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) op = 4'hF;
      else op = 4'($urandom_range(0, 14));
      drive(1'($urandom_range(0, 1)), op);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random cyc %0d op %h got %h exp %h", i, op, obs, expv);
      end
      advance();
      haltedFor = (mMode == M_HALTED) ? haltedFor + 1 : 0;
      if (haltedFor > 4 || $urandom_range(0, 149) == 0) begin
        doReset();
        haltedFor = 0;
      end
    end
  endtask

  initial begin
    buildTable();
    modelReset();
    reset    = 1'b1;
    start    = 1'b0;
    opcodeDP = 4'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_decode();
    test_branch();
    test_halt();
    test_illegal();
    test_saturate();
    test_reset_in_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
